// File: rtl/warp_regfile.sv
// warp_regfile: per-thread SIMT register file.
//
// Each of NUM_THREADS threads owns a private bank of general registers.
// Indices SPECIAL_BASE..31 are read-only per-thread special values:
// tIdx, bIdx, bDim and a global id.
// A bank-clear engine zeroes one thread bank per cycle. It runs after
// reset and again on clear_req. While it runs, reads and writes are
// dropped and the predicates read as all ones.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   clear_req/clear_busy  start pulse / activity flag of the clear engine
//   rd_en, rd_thread      read request and the thread being read
//   ad1, ad2              read addresses
//   rd1, rd2              registered read data, 1-cycle latency
//   rd_valid              read data valid this cycle
//   a0                    registered x10 of rd_thread
//   wr_en, wr_bcast       write request; broadcast select
//   wr_thread, wr_mask    target thread (unicast) or thread mask (broadcast)
//   ad3, wd3              write address and data
//   b_idx                 block index used by the special registers
//   pred_we, pred_thread  predicate write enable and target thread
//   pred_wd               predicate write value
//   pred_q                registered predicate bits, one per thread
module warp_regfile #(
  parameter int NUM_THREADS  = 16,
  parameter int NUM_REGS     = 32,
  parameter int DATA_W       = 32,
  parameter int SPECIAL_BASE = 28,
  parameter int BLOCK_DIM    = 16,
  localparam int TID_W       = $clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_req,
  output logic                   clear_busy,
  input  logic                   rd_en,
  input  logic [TID_W-1:0]       rd_thread,
  input  logic [4:0]             ad1,
  input  logic [4:0]             ad2,
  output logic [DATA_W-1:0]      rd1,
  output logic [DATA_W-1:0]      rd2,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      a0,
  input  logic                   wr_en,
  input  logic                   wr_bcast,
  input  logic [TID_W-1:0]       wr_thread,
  input  logic [NUM_THREADS-1:0] wr_mask,
  input  logic [4:0]             ad3,
  input  logic [DATA_W-1:0]      wd3,
  input  logic [DATA_W-1:0]      b_idx,
  input  logic                   pred_we,
  input  logic [TID_W-1:0]       pred_thread,
  input  logic                   pred_wd,
  output logic [NUM_THREADS-1:0] pred_q
);

  localparam logic [4:0] SPEC_IDX = 5'(SPECIAL_BASE);
  localparam logic [4:0] A0_IDX   = 5'd10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [TID_W-1:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]        bank_q [NUM_THREADS][NUM_REGS];
  logic [DATA_W-1:0]        bank_d [NUM_THREADS][NUM_REGS];
  logic [DATA_W-1:0]        rd1_q, rd1_d;
  logic [DATA_W-1:0]        rd2_q, rd2_d;
  logic [DATA_W-1:0]        a0_q, a0_d;
  logic                     rd_valid_q, rd_valid_d;
  logic [NUM_THREADS-1:0]   pred_d;
  logic                     wr_ok_s;
  logic [NUM_THREADS-1:0]   wr_hit_s;
  logic                     rd_byp_s;

  // Value seen by a read port: zero register, bank entry with write-first
  // bypass, or one of the per-thread special values.
  function automatic logic [DATA_W-1:0] read_word(
    input logic [4:0]        ad,
    input logic [DATA_W-1:0] stored,
    input logic [TID_W-1:0]  tid,
    input logic [DATA_W-1:0] bidx,
    input logic              byp,
    input logic [4:0]        wad,
    input logic [DATA_W-1:0] wdata
  );
    logic [DATA_W-1:0] v;
    v = '0;
    if (ad == 5'd0) begin
      v = '0;
    end else if (ad < SPEC_IDX) begin
      v = (byp && (wad == ad)) ? wdata : stored;
    end else begin
      case (ad)
        SPEC_IDX:        v = DATA_W'(tid);
        SPEC_IDX + 5'd1: v = bidx;
        SPEC_IDX + 5'd2: v = DATA_W'(BLOCK_DIM);
        default:         v = bidx * DATA_W'(BLOCK_DIM) + DATA_W'(tid);
      endcase
    end
    return v;
  endfunction

  // Clear-engine sequencing: one thread bank per cycle, then RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + TID_W'(1);
        if (cnt_q == TID_W'(NUM_THREADS - 1)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Write acceptance and per-thread targets; broadcasts use the current
  // predicates, before any same-cycle predicate update.
  always_comb begin
    wr_ok_s = (state_q == ST_RUN) && wr_en && (ad3 != 5'd0) && (ad3 < SPEC_IDX);
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (wr_bcast) begin
        wr_hit_s[t] = wr_ok_s & wr_mask[t] & pred_q[t];
      end else begin
        wr_hit_s[t] = wr_ok_s & (wr_thread == TID_W'(t));
      end
    end
    rd_byp_s = wr_hit_s[rd_thread];
  end

  // Bank next state: clear one whole thread, or apply the accepted write.
  always_comb begin
    bank_d = bank_q;
    if (state_q == ST_CLEAR) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        bank_d[cnt_q][r] = '0;
      end
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (wr_hit_s[t]) begin
          bank_d[t][ad3] = wd3;
        end else begin
          bank_d[t][ad3] = bank_q[t][ad3];
        end
      end
    end
  end

  // Read ports: data holds when no read is accepted.
  always_comb begin
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    a0_d       = a0_q;
    rd_valid_d = 1'b0;
    if ((state_q == ST_RUN) && rd_en) begin
      rd_valid_d = 1'b1;
      rd1_d = read_word(ad1, bank_q[rd_thread][ad1], rd_thread, b_idx, rd_byp_s, ad3, wd3);
      rd2_d = read_word(ad2, bank_q[rd_thread][ad2], rd_thread, b_idx, rd_byp_s, ad3, wd3);
      a0_d  = read_word(A0_IDX, bank_q[rd_thread][A0_IDX], rd_thread, b_idx, rd_byp_s, ad3, wd3);
    end else begin
      rd_valid_d = 1'b0;
    end
  end

  // Predicates: forced to all ones whenever the clear engine is (or will be) active.
  always_comb begin
    pred_d = pred_q;
    if ((state_q == ST_RUN) && pred_we) begin
      pred_d[pred_thread] = pred_wd;
    end else begin
      pred_d = pred_q;
    end
    if (state_d == ST_CLEAR) begin
      pred_d = '1;
    end else begin
      pred_d = pred_d;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      a0_q       <= '0;
      rd_valid_q <= 1'b0;
      pred_q     <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      a0_q       <= a0_d;
      rd_valid_q <= rd_valid_d;
      pred_q     <= pred_d;
    end
  end

  // Bank storage; its contents are established by the clear engine after reset.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

  assign clear_busy = (state_q == ST_CLEAR);
  assign rd1        = rd1_q;
  assign rd2        = rd2_q;
  assign a0         = a0_q;
  assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_warp_regfile.sv
module tb_warp_regfile;

  localparam int NT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_req = 1'b0;
  logic        clear_busy;
  logic        rd_en = 1'b0;
  logic [3:0]  rd_thread = 4'd0;
  logic [4:0]  ad1 = 5'd0, ad2 = 5'd0, ad3 = 5'd0;
  logic [31:0] rd1, rd2, a0;
  logic        rd_valid;
  logic        wr_en = 1'b0, wr_bcast = 1'b0;
  logic [3:0]  wr_thread = 4'd0;
  logic [15:0] wr_mask = 16'd0;
  logic [31:0] wd3 = 32'd0, b_idx = 32'd0;
  logic        pred_we = 1'b0, pred_wd = 1'b0;
  logic [3:0]  pred_thread = 4'd0;
  logic [15:0] pred_q;

  int nchk = 0;
  int nerr = 0;

  typedef struct packed {
    logic        wr; logic bc; logic [3:0] wt; logic [15:0] wm; logic [4:0] a3; logic [31:0] wd;
    logic        rd; logic [3:0] rt; logic [4:0] a1; logic [4:0] a2; logic [31:0] bi;
    logic        pw; logic [3:0] pt; logic pv;
    logic        ev; logic [31:0] e1; logic [31:0] e2; logic [31:0] ea;
  } vec_t;

  // Reference model state
  logic [31:0] mbank [NT][32];
  logic [15:0] mpred;
  logic        mv;
  logic [31:0] m1, m2, ma;

  warp_regfile dut (
    .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .clear_busy(clear_busy),
    .rd_en(rd_en), .rd_thread(rd_thread), .ad1(ad1), .ad2(ad2),
    .rd1(rd1), .rd2(rd2), .rd_valid(rd_valid), .a0(a0),
    .wr_en(wr_en), .wr_bcast(wr_bcast), .wr_thread(wr_thread), .wr_mask(wr_mask),
    .ad3(ad3), .wd3(wd3), .b_idx(b_idx),
    .pred_we(pred_we), .pred_thread(pred_thread), .pred_wd(pred_wd), .pred_q(pred_q)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    input logic wr, input logic bc, input logic [3:0] wt, input logic [15:0] wm,
    input logic [4:0] a3, input logic [31:0] wd,
    input logic rd, input logic [3:0] rt, input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] bi,
    input logic pw, input logic [3:0] pt, input logic pv,
    input logic ev, input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] ea);
    vec_t v;
    v.wr = wr; v.bc = bc; v.wt = wt; v.wm = wm; v.a3 = a3; v.wd = wd;
    v.rd = rd; v.rt = rt; v.a1 = a1; v.a2 = a2; v.bi = bi;
    v.pw = pw; v.pt = pt; v.pv = pv;
    v.ev = ev; v.e1 = e1; v.e2 = e2; v.ea = ea;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    wr_en = v.wr; wr_bcast = v.bc; wr_thread = v.wt; wr_mask = v.wm; ad3 = v.a3; wd3 = v.wd;
    rd_en = v.rd; rd_thread = v.rt; ad1 = v.a1; ad2 = v.a2; b_idx = v.bi;
    pred_we = v.pw; pred_thread = v.pt; pred_wd = v.pv;
  endtask

  task automatic idle();
    drive(mk(0,0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0));
    clear_req = 1'b0;
  endtask

  task automatic mclear();
    for (int t = 0; t < NT; t++)
      for (int r = 0; r < 32; r++) mbank[t][r] = 32'd0;
    mpred = 16'hFFFF;
  endtask

  // Architectural value of register a for thread t, after this cycle's write.
  function automatic logic [31:0] mread(input int t, input logic [4:0] a, input logic [31:0] bi);
    if (a == 5'd0) return 32'd0;
    if (a < 5'd28) return mbank[t][a];
    if (a == 5'd28) return 32'(t);
    if (a == 5'd29) return bi;
    if (a == 5'd30) return 32'd16;
    return bi * 32'd16 + 32'(t);
  endfunction

  // Write-first semantics: apply the write (with old predicates), then read.
  task automatic mstep(input vec_t v);
    logic [15:0] op;
    op = mpred;
    if (v.wr && v.a3 != 5'd0 && v.a3 < 5'd28) begin
      for (int t = 0; t < NT; t++) begin
        if (v.bc ? (v.wm[t] && op[t]) : (int'(v.wt) == t)) mbank[t][v.a3] = v.wd;
      end
    end
    if (v.pw) mpred[v.pt] = v.pv;
    mv = v.rd;
    if (v.rd) begin
      m1 = mread(int'(v.rt), v.a1, v.bi);
      m2 = mread(int'(v.rt), v.a2, v.bi);
      ma = mread(int'(v.rt), 5'd10, v.bi);
    end
  endtask

  // Counts busy samples while hammering the dropped read/write/predicate inputs.
  task automatic count_busy(input string nm, input int expect_cycles);
    int cnt;
    cnt = 0;
    while (clear_busy && cnt < 40) begin
      cnt++;
      drive(mk(1,0,4'd7,0,5'd9,32'h1111_1111, 1,4'd7,5'd9,5'd9,0, 1,4'd0,1'b0, 0,0,0,0));
      clear_req = (cnt == 3);
      step();
      if (clear_busy) begin
        chk({nm, "_rdvalid_busy"}, {31'd0, rd_valid}, 32'd0);
        chk({nm, "_pred_busy"}, {16'd0, pred_q}, 32'h0000_FFFF);
      end
    end
    idle();
    chk({nm, "_busy_cycles"}, cnt, expect_cycles);
  endtask

  vec_t tbl [18];
  vec_t rv;

  initial begin
    idle();
    mclear();
    m1 = 0; m2 = 0; ma = 0; mv = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd1", rd1, 32'd0);
    chk("rst_rd2", rd2, 32'd0);
    chk("rst_a0", a0, 32'd0);
    chk("rst_rdvalid", {31'd0, rd_valid}, 32'd0);
    chk("rst_busy", {31'd0, clear_busy}, 32'd1);
    chk("rst_pred", {16'd0, pred_q}, 32'h0000_FFFF);
    @(negedge clk) rst_n = 1'b1;
    count_busy("init", 16);
    chk("init_pred", {16'd0, pred_q}, 32'h0000_FFFF);

    // Every thread/register reads zero after the clear
    for (int t = 0; t < NT; t++) begin
      for (int r = 0; r < 28; r++) begin
        drive(mk(0,0,0,0,0,0, 1,4'(t),5'(r),5'(27 - r),0, 0,0,0, 0,0,0,0));
        step();
        chk("zero_rd1", rd1, 32'd0);
        chk("zero_rd2", rd2, 32'd0);
      end
    end
    chk("zero_a0", a0, 32'd0);
    chk("zero_valid", {31'd0, rd_valid}, 32'd1);
    idle();
    step();
    chk("idle_valid", {31'd0, rd_valid}, 32'd0);

    //         wr bc wt    wm        a3     wd            rd rt    a1     a2     bi     pw pt    pv   ev e1            e2         ea
    tbl[0]  = mk(1,0,4'd3,16'h0,    5'd5,  32'hDEADBEEF, 0,4'd0,5'd0,  5'd0,  32'd0, 0,4'd0,1'b0, 0,32'd0,       32'd0,     32'd0);
    tbl[1]  = mk(0,0,4'd0,16'h0,    5'd0,  32'd0,        1,4'd3,5'd5,  5'd0,  32'd0, 0,4'd0,1'b0, 1,32'hDEADBEEF,32'd0,     32'd0);
    tbl[2]  = mk(0,0,4'd0,16'h0,    5'd0,  32'd0,        1,4'd4,5'd5,  5'd0,  32'd0, 0,4'd0,1'b0, 1,32'd0,       32'd0,     32'd0);
    tbl[3]  = mk(0,0,4'd0,16'h0,    5'd0,  32'd0,        0,4'd0,5'd0,  5'd0,  32'd0, 0,4'd0,1'b0, 0,32'd0,       32'd0,     32'd0);
    tbl[4]  = mk(1,0,4'd2,16'h0,    5'd10, 32'h1234,     1,4'd2,5'd10, 5'd5,  32'd0, 0,4'd0,1'b0, 1,32'h1234,    32'd0,     32'h1234);
    tbl[5]  = mk(0,0,4'd0,16'h0,    5'd0,  32'd0,        0,4'd0,5'd0,  5'd0,  32'd0, 1,4'd1,1'b0, 0,32'h1234,    32'd0,     32'h1234);
    tbl[6]  = mk(1,1,4'd9,16'h0003, 5'd7,  32'h55,       0,4'd0,5'd0,  5'd0,  32'd0, 0,4'd0,1'b0, 0,32'h1234,    32'd0,     32'h1234);
    tbl[7]  = mk(0,0,4'd0,16'h0,    5'd0,  32'd0,        1,4'd0,5'd7,  5'd10, 32'd0, 0,4'd0,1'b0, 1,32'h55,      32'd0,     32'd0);
    tbl[8]  = mk(0,0,4'd0,16'h0,    5'd0,  32'd0,        1,4'd1,5'd7,  5'd7,  32'd0, 0,4'd0,1'b0, 1,32'd0,       32'd0,     32'd0);
    tbl[9]  = mk(0,0,4'd0,16'h0,    5'd0,  32'd0,        1,4'd2,5'd7,  5'd10, 32'd0, 0,4'd0,1'b0, 1,32'd0,       32'h1234,  32'h1234);
    tbl[10] = mk(0,0,4'd0,16'h0,    5'd0,  32'd0,        1,4'd5,5'd28, 5'd31, 32'd2, 0,4'd0,1'b0, 1,32'd5,       32'd37,    32'd0);
    tbl[11] = mk(0,0,4'd0,16'h0,    5'd0,  32'd0,        1,4'd5,5'd29, 5'd30, 32'd2, 0,4'd0,1'b0, 1,32'd2,       32'd16,    32'd0);
    tbl[12] = mk(1,0,4'd5,16'h0,    5'd28, 32'hFFFF,     1,4'd5,5'd28, 5'd0,  32'd2, 0,4'd0,1'b0, 1,32'd5,       32'd0,     32'd0);
    tbl[13] = mk(1,0,4'd5,16'h0,    5'd0,  32'd99,       1,4'd5,5'd0,  5'd28, 32'd2, 0,4'd0,1'b0, 1,32'd0,       32'd5,     32'd0);
    tbl[14] = mk(1,1,4'd0,16'h0003, 5'd3,  32'hAA,       0,4'd0,5'd0,  5'd0,  32'd0, 1,4'd0,1'b0, 0,32'd0,       32'd5,     32'd0);
    tbl[15] = mk(0,0,4'd0,16'h0,    5'd0,  32'd0,        1,4'd0,5'd3,  5'd3,  32'd0, 0,4'd0,1'b0, 1,32'hAA,      32'hAA,    32'd0);
    tbl[16] = mk(1,1,4'd0,16'h0001, 5'd3,  32'hBB,       1,4'd0,5'd3,  5'd7,  32'd0, 0,4'd0,1'b0, 1,32'hAA,      32'h55,    32'd0);
    tbl[17] = mk(0,0,4'd0,16'h0,    5'd0,  32'd0,        1,4'd1,5'd3,  5'd28, 32'd0, 0,4'd0,1'b0, 1,32'd0,       32'd1,     32'd0);

    for (int i = 0; i < 18; i++) begin
      mstep(tbl[i]);
      drive(tbl[i]);
      step();
      chk($sformatf("vec%0d_valid", i), {31'd0, rd_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("vec%0d_rd1", i), rd1, tbl[i].e1);
      chk($sformatf("vec%0d_rd2", i), rd2, tbl[i].e2);
      chk($sformatf("vec%0d_a0", i), a0, tbl[i].ea);
    end
    chk("vec_pred", {16'd0, pred_q}, 32'h0000_FFFC);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rv = mk(($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 3)),
              16'($urandom()),
              ($urandom_range(0, 7) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 15)),
              $urandom(),
              ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 15)),
              ($urandom_range(0, 7) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 15)),
              $urandom(),
              ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              0, 0, 0, 0);
      mstep(rv);
      drive(rv);
      step();
      chk("rnd_valid", {31'd0, rd_valid}, {31'd0, mv});
      chk("rnd_rd1", rd1, m1);
      chk("rnd_rd2", rd2, m2);
      chk("rnd_a0", a0, ma);
      chk("rnd_pred", {16'd0, pred_q}, {16'd0, mpred});
    end
    idle();

    // clear_req with data present; a second request during busy does not extend it
    drive(mk(1,0,4'd7,0,5'd9,32'd77, 0,0,0,0,0, 0,0,0, 0,0,0,0));
    step();
    drive(mk(0,0,0,0,0,0, 1,4'd7,5'd9,5'd9,0, 0,0,0, 0,0,0,0));
    step();
    chk("pre_clear_rd1", rd1, 32'd77);
    idle();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    chk("clr_busy_start", {31'd0, clear_busy}, 32'd1);
    count_busy("clr", 16);
    mclear();

    // Reset pulsed mid-clear aborts and a full clear follows
    drive(mk(1,1,0,16'hFFFF,5'd9,32'd88, 0,0,0,0,0, 0,0,0, 0,0,0,0));
    step();
    drive(mk(0,0,0,0,0,0, 1,4'd7,5'd9,5'd9,0, 0,0,0, 0,0,0,0));
    step();
    chk("pre_rst_rd1", rd1, 32'd88);
    idle();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rd1", rd1, 32'd0);
    chk("abort_busy", {31'd0, clear_busy}, 32'd1);
    @(negedge clk) rst_n = 1'b1;
    count_busy("rst_clr", 16);
    mclear();
    chk("post_pred", {16'd0, pred_q}, 32'h0000_FFFF);
    for (int t = 0; t < NT; t++) begin
      rv = mk(0,0,0,0,0,0, 1,4'(t),5'd9,5'd5,0, 0,0,0, 0,0,0,0);
      mstep(rv);
      drive(rv);
      step();
      chk("post_rd1", rd1, m1);
      chk("post_rd2", rd2, m2);
    end
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
